// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: memory-arbiter state encoding and the load
// half-word mode constants that main control also produces.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GNT_IF = 2'b01,
        GNT_D  = 2'b10,
        RESP   = 2'b11
    } arb_state_t;

    localparam logic [1:0] HW_WORD  = 2'b00;
    localparam logic [1:0] HW_UHALF = 2'b10;
    localparam logic [1:0] HW_SHALF = 2'b11;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory bus of the unified-memory arbiter.
// master = arbiter side, slave = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_hw;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  d_req, d_we, d_hw, d_addr, d_wdata,
        output d_rdata, d_ack,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output d_req, d_we, d_hw, d_addr, d_wdata,
        input  d_rdata, d_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/load_formatter.sv
// Combinational load formatting: word pass-through, or the half selected by
// addr[1] with zero (HW_UHALF) or sign (HW_SHALF) extension.
module load_formatter
    import mips_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  hw,
    input  logic        a1,
    output logic [31:0] fdata
);

    logic [15:0] half;

    // NOTE: every always_comb output gets a value on every path (default
    // first or a full case with default) so no latch is inferred.
    always_comb begin
        half = a1 ? rdata[31:16] : rdata[15:0];
        case (hw)
            HW_UHALF: fdata = {16'h0000, half};
            HW_SHALF: fdata = {{16{half[15]}}, half};
            default:  fdata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter between fetch and memory stage; data has
// priority. Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.master bus
);

    if (DATA_W != 32 || STARVE_MAX < 1) begin : g_cfg_check
        $error("mem_port_arbiter: DATA_W must be 32 and STARVE_MAX at least 1");
    end

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [1:0]        hw_q, hw_d;
    logic              we_q, we_d;
    logic              a1_q, a1_d;
    logic              d_sel_q, d_sel_d;
    logic [DATA_W-1:0] fmt_data;
    logic              grant_d, grant_if, fetch_force;

    load_formatter u_fmt (
        .rdata (bus.mem_rdata),
        .hw    (hw_q),
        .a1    (a1_q),
        .fdata (fmt_data)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign fetch_force = (starve_q == CNT_W'(STARVE_MAX));

    // Counts data grants taken while fetch was waiting; any fetch grant or an
    // idle fetch port restarts the count.
    always_comb begin
        starve_d = starve_q;
        if (!bus.if_req)
            starve_d = '0;
        else if (state_q == IDLE && grant_if)
            starve_d = '0;
        else if (state_q == IDLE && grant_d && !fetch_force)
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) starve_q <= '0;
        else        starve_q <= starve_d;
    end
`else
    assign fetch_force = 1'b0;
`endif

    assign grant_d  = bus.d_req && !(fetch_force && bus.if_req);
    assign grant_if = bus.if_req && !grant_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        hw_d       = hw_q;
        a1_d       = a1_q;
        d_sel_d    = d_sel_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = GNT_D;
                    addr_d  = bus.d_addr & ~ADDR_W'(3);
                    wdata_d = bus.d_wdata;
                    we_d    = bus.d_we;
                    hw_d    = bus.d_hw;
                    a1_d    = bus.d_addr[1];
                    d_sel_d = 1'b1;
                end else if (grant_if) begin
                    state_d = GNT_IF;
                    addr_d  = bus.if_addr & ~ADDR_W'(3);
                    we_d    = 1'b0;
                    hw_d    = HW_WORD;
                    a1_d    = bus.if_addr[1];
                    d_sel_d = 1'b0;
                end
            end
            GNT_IF, GNT_D: begin
                if (bus.mem_ready) begin
                    state_d = RESP;
                    if (!d_sel_q)
                        if_rdata_d = bus.mem_rdata;
                    else if (!we_q)
                        d_rdata_d = fmt_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            hw_q       <= HW_WORD;
            a1_q       <= 1'b0;
            d_sel_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            hw_q       <= hw_d;
            a1_q       <= a1_d;
            d_sel_q    <= d_sel_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign bus.mem_req   = (state_q == GNT_IF) || (state_q == GNT_D);
    assign bus.mem_we    = (state_q == GNT_D) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ack    = (state_q == RESP) && !d_sel_q;
    assign bus.d_ack     = (state_q == RESP) && d_sel_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a negedge process models memory,
// drives both requesters from queues and compares grants and acks.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } ack_exp_t;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
    } gnt_exp_t;

    typedef struct {
        bit          we;
        logic [1:0]  hw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } d_txn_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ack_exp_t    ack_q[$];
    gnt_exp_t    gnt_q[$];
    d_txn_t      d_q[$];
    logic [31:0] i_q[$];

    int vectors = 0;
    int errors  = 0;
    int cyc = 0;
    int wait_cycles = 0;
    int mem_cnt = 0;
    int ack_count = 0;
    int req_len = 0;
    int last_req_len = 0;
    int last_if_ack_cyc = 0;
    int prev_if_ack_cyc = 0;
    bit force_ready = 1'b0;
    bit d_active = 1'b0;
    bit i_active = 1'b0;
    bit prev_req = 1'b0;
    bit prev_if_ack = 1'b0;
    bit prev_d_ack = 1'b0;
    bit gnt_valid = 1'b0;
    gnt_exp_t    cur_gnt;
    logic [31:0] exp_d_rdata = 32'h0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h8C22_0004;
            32'h0000_0100: return 32'h8001_1234;
            default:       return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
        endcase
    endfunction

    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] hw,
                                        input logic [31:0] a);
        logic [31:0] h;
        if (hw[1]) begin
            h = a[1] ? (w >> 16) : (w & 32'h0000_FFFF);
            if (hw[0] && h[15]) h = h | 32'hFFFF_0000;
            return h;
        end
        return w;
    endfunction

    task automatic exp_fetch(input logic [31:0] a);
        logic [31:0] wa;
        wa = a & 32'hFFFF_FFFC;
        gnt_q.push_back('{addr: wa, we: 1'b0, wdata: 32'h0});
        ack_q.push_back('{is_d: 1'b0, data: mem_val(wa)});
    endtask

    task automatic exp_data(input d_txn_t t, input bit use_exp, input logic [31:0] expv);
        logic [31:0] wa;
        wa = t.addr & 32'hFFFF_FFFC;
        if (t.we) begin
            gnt_q.push_back('{addr: wa, we: 1'b1, wdata: t.wdata});
        end else begin
            exp_d_rdata = use_exp ? expv : fmt(mem_val(wa), t.hw, t.addr);
            gnt_q.push_back('{addr: wa, we: 1'b0, wdata: 32'h0});
        end
        ack_q.push_back('{is_d: 1'b1, data: exp_d_rdata});
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic flush_all();
        ack_q.delete();
        gnt_q.delete();
        d_q.delete();
        i_q.delete();
        d_active  = 1'b0;
        i_active  = 1'b0;
        bus.d_req = 1'b0;
        bus.if_req = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n;
        n = 0;
        while ((ack_q.size() != 0 || gnt_q.size() != 0 || d_q.size() != 0 ||
                i_q.size() != 0) && n < bound) begin
            step();
            n++;
        end
        vectors++;
        if (n >= bound) begin
            errors++;
            $display("FAIL %s_timeout: %0d acks still pending after %0d cycles, want 0",
                     name, ack_q.size(), bound);
            flush_all();
        end
        repeat (2) step();
    endtask

    // Monitor, memory model and requester drivers share one process so their
    // order within a cycle is fixed.
    initial begin
        gnt_exp_t e_g;
        ack_exp_t e_a;
        forever begin
            @(negedge clk);
            cyc++;

            if (bus.if_ack === 1'b1 || bus.d_ack === 1'b1) begin
                ack_count++;
                vectors++;
                if (bus.if_ack === 1'b1 && bus.d_ack === 1'b1) begin
                    errors++;
                    $display("FAIL dual_ack: if_ack=1 d_ack=1, want one");
                end else if (ack_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: if_ack=%b d_ack=%b, want none",
                             bus.if_ack, bus.d_ack);
                end else begin
                    e_a = ack_q.pop_front();
                    if (e_a.is_d != bus.d_ack) begin
                        errors++;
                        $display("FAIL ack_order: got d_ack=%b, want d_ack=%b", bus.d_ack, e_a.is_d);
                    end else if (e_a.is_d && bus.d_rdata !== e_a.data) begin
                        errors++;
                        $display("FAIL d_rdata: got %h, want %h", bus.d_rdata, e_a.data);
                    end else if (!e_a.is_d && bus.if_rdata !== e_a.data) begin
                        errors++;
                        $display("FAIL if_rdata: got %h, want %h", bus.if_rdata, e_a.data);
                    end
                end
                if ((bus.if_ack === 1'b1 && prev_if_ack) || (bus.d_ack === 1'b1 && prev_d_ack)) begin
                    errors++;
                    $display("FAIL ack_width: ack high 2+ cycles, want 1");
                end
                if (bus.if_ack === 1'b1) begin
                    prev_if_ack_cyc = last_if_ack_cyc;
                    last_if_ack_cyc = cyc;
                end
            end
            prev_if_ack = (bus.if_ack === 1'b1);
            prev_d_ack  = (bus.d_ack === 1'b1);

            if (bus.mem_req === 1'b1) begin
                if (!prev_req) begin
                    req_len = 0;
                    vectors++;
                    if (gnt_q.size() == 0) begin
                        gnt_valid = 1'b0;
                        errors++;
                        $display("FAIL unexpected_grant: mem_req=1 addr=%h, want no grant", bus.mem_addr);
                    end else begin
                        e_g = gnt_q.pop_front();
                        cur_gnt = e_g;
                        gnt_valid = 1'b1;
                    end
                end
                req_len++;
                if (gnt_valid) begin
                    vectors++;
                    if (bus.mem_addr !== cur_gnt.addr || bus.mem_we !== cur_gnt.we ||
                        (cur_gnt.we && bus.mem_wdata !== cur_gnt.wdata)) begin
                        errors++;
                        $display("FAIL mem_bus: addr=%h we=%b wdata=%h, want addr=%h we=%b wdata=%h",
                                 bus.mem_addr, bus.mem_we, bus.mem_wdata,
                                 cur_gnt.addr, cur_gnt.we, cur_gnt.wdata);
                    end
                end
            end else if (prev_req) begin
                last_req_len = req_len;
            end
            prev_req = (bus.mem_req === 1'b1);

            if (bus.mem_req === 1'b1) begin
                mem_cnt++;
                if (mem_cnt > wait_cycles) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_val(bus.mem_addr);
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = $urandom;
                end
            end else begin
                mem_cnt = 0;
                bus.mem_ready = force_ready;
                bus.mem_rdata = $urandom;
            end

            if (d_active && bus.d_ack === 1'b1) begin
                void'(d_q.pop_front());
                d_active  = 1'b0;
                bus.d_req = 1'b0;
                bus.d_addr = $urandom;
            end
            if (!d_active && d_q.size() > 0) begin
                bus.d_req   = 1'b1;
                bus.d_we    = d_q[0].we;
                bus.d_hw    = d_q[0].hw;
                bus.d_addr  = d_q[0].addr;
                bus.d_wdata = d_q[0].wdata;
                d_active    = 1'b1;
            end
            if (i_active && bus.if_ack === 1'b1) begin
                void'(i_q.pop_front());
                i_active   = 1'b0;
                bus.if_req = 1'b0;
                bus.if_addr = $urandom;
            end
            if (!i_active && i_q.size() > 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = i_q[0];
                i_active    = 1'b1;
            end
        end
    end

    task automatic test_reset();
        repeat (2) step();
        vectors++;
        if ({bus.if_ack, bus.d_ack, bus.mem_req, bus.mem_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: if_ack,d_ack,mem_req,mem_we=%b, want 0000",
                     {bus.if_ack, bus.d_ack, bus.mem_req, bus.mem_we});
        end
        vectors++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem: addr=%h wdata=%h, want 0", bus.mem_addr, bus.mem_wdata);
        end
        vectors++;
        if (bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: if=%h d=%h, want 0", bus.if_rdata, bus.d_rdata);
        end
        reset = 1'b1;
        repeat (2) step();
        vectors++;
        if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: mem_req=%b, want 0", bus.mem_req);
        end
    endtask

    task automatic test_fetch();
        wait_cycles = 2;
        i_q.push_back(32'h40);
        exp_fetch(32'h40);
        wait_idle(40, "fetch");
        vectors++;
        if (last_req_len != 3) begin
            errors++;
            $display("FAIL fetch_req_len: mem_req high %0d cycles, want 3", last_req_len);
        end
        repeat (3) step();
        vectors++;
        if (bus.if_rdata !== 32'h8C22_0004) begin
            errors++;
            $display("FAIL if_rdata_hold: got %h, want 8c220004", bus.if_rdata);
        end
    endtask

    task automatic test_priority();
        d_txn_t t;
        wait_cycles = 0;
        t = '{we: 1'b1, hw: 2'b11, addr: 32'h100, wdata: 32'hDEAD_BEEF};
        d_q.push_back(t);
        i_q.push_back(32'h200);
        exp_data(t, 1'b0, 32'h0);
        exp_fetch(32'h200);
        wait_idle(40, "priority");
    endtask

    task automatic test_load_format();
        d_txn_t t;
        logic [31:0] a_tab [7] = '{32'h102, 32'h102, 32'h100, 32'h100, 32'h103, 32'h100, 32'h101};
        logic [1:0]  m_tab [7] = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00};
        logic [31:0] e_tab [7] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_1234, 32'h0000_1234,
                                   32'hFFFF_8001, 32'h8001_1234, 32'h8001_1234};
        wait_cycles = 0;
        for (int i = 0; i < 7; i++) begin
            t = '{we: 1'b0, hw: m_tab[i], addr: a_tab[i], wdata: $urandom};
            d_q.push_back(t);
            exp_data(t, 1'b1, e_tab[i]);
        end
        t = '{we: 1'b1, hw: 2'b11, addr: 32'h1F0, wdata: 32'h1234_5678};
        d_q.push_back(t);
        exp_data(t, 1'b0, 32'h0);
        wait_idle(80, "load_table");

        wait_cycles = 1;
        for (int i = 0; i < 6; i++) begin
            t.we    = 1'b0;
            t.hw    = 2'($urandom_range(0, 3));
            t.addr  = 32'h800 + 32'($urandom_range(0, 255));
            t.wdata = $urandom;
            d_q.push_back(t);
            exp_data(t, 1'b0, 32'h0);
        end
        wait_idle(80, "load_rand");
    endtask

    task automatic test_back_to_back();
        wait_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            i_q.push_back(32'h4 * i);
            exp_fetch(32'h4 * i);
        end
        wait_idle(40, "b2b");
        vectors++;
        if (last_if_ack_cyc - prev_if_ack_cyc != 3) begin
            errors++;
            $display("FAIL b2b_spacing: acks %0d cycles apart, want 3",
                     last_if_ack_cyc - prev_if_ack_cyc);
        end
    endtask

    task automatic test_reset_abort();
        d_txn_t t;
        int acks_before;
        wait_cycles = 20;
        t = '{we: 1'b0, hw: 2'b00, addr: 32'h104, wdata: 32'h0};
        d_q.push_back(t);
        exp_data(t, 1'b0, 32'h0);
        repeat (3) step();
        vectors++;
        if (bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL abort_granted: mem_req=%b, want 1", bus.mem_req);
        end
        reset = 1'b0;
        flush_all();
        exp_d_rdata = 32'h0;
        #1;
        vectors++;
        if ({bus.if_ack, bus.d_ack, bus.mem_req, bus.mem_we} !== 4'b0000 ||
            bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 ||
            bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL abort_reset_outputs: ctrl=%b addr=%h wdata=%h if=%h d=%h, want all 0",
                     {bus.if_ack, bus.d_ack, bus.mem_req, bus.mem_we}, bus.mem_addr,
                     bus.mem_wdata, bus.if_rdata, bus.d_rdata);
        end
        repeat (2) step();
        reset = 1'b1;
        acks_before = ack_count;
        force_ready = 1'b1;
        step();
        force_ready = 1'b0;
        repeat (4) step();
        vectors++;
        if (ack_count != acks_before || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL late_ready: %0d acks mem_req=%b, want 0 acks mem_req=0",
                     ack_count - acks_before, bus.mem_req);
        end
        wait_cycles = 1;
        t = '{we: 1'b0, hw: 2'b11, addr: 32'h102, wdata: 32'h0};
        d_q.push_back(t);
        exp_data(t, 1'b1, 32'hFFFF_8001);
        i_q.push_back(32'h40);
        exp_fetch(32'h40);
        wait_idle(40, "after_reset");
    endtask

    task automatic test_starve();
        d_txn_t t [6];
        wait_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            t[i] = '{we: 1'b0, hw: 2'b00, addr: 32'h300 + 32'(4 * i), wdata: 32'h0};
            d_q.push_back(t[i]);
        end
        i_q.push_back(32'h500);
`ifdef MEM_ARB_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) exp_data(t[i], 1'b0, 32'h0);
        exp_fetch(32'h500);
        for (int i = 4; i < 6; i++) exp_data(t[i], 1'b0, 32'h0);
`else
        for (int i = 0; i < 6; i++) exp_data(t[i], 1'b0, 32'h0);
        exp_fetch(32'h500);
`endif
        wait_idle(80, "starve");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_hw      = 2'b00;
        bus.d_addr    = 32'h0;
        bus.d_wdata   = 32'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ready = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;

        test_reset();
        test_fetch();
        test_priority();
        test_load_format();
        test_back_to_back();
        test_reset_abort();
        test_starve();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified instruction/data memory between the fetch stage and the memory stage of the MIPS pipeline. Registered FSM grants one requester at a time, holds address/write data stable until the memory signals ready, then returns read data with a one-cycle acknowledge. Data-side loads are formatted according to the half-word mode produced by main control (word, unsigned half, signed half).

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width (fixed 32 for half-word formatting).
- `STARVE_MAX`, 4, max consecutive data grants while fetch waits (guard build only).

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch read request, held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetched word, valid with `if_ack`, held until next `if_ack`.
- `if_ack`  out  1  one-cycle fetch completion pulse.
- `d_req`  in  1  data request, held until `d_ack`.
- `d_we`  in  1  1 = store word, 0 = load.
- `d_hw`  in  2  load mode: 2'b00 word, 2'b10 unsigned half, 2'b11 signed half.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  DATA_W  store data.
- `d_rdata`  out  DATA_W  formatted load data, valid with `d_ack`, held until next `d_ack`.
- `d_ack`  out  1  one-cycle data completion pulse (loads and stores).
- `mem_req`  out  1  memory access active.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  word-aligned memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid when `mem_ready`.
- `mem_ready`  in  1  memory completion, sampled only while `mem_req`=1.

## Operation
- States: IDLE, GNT_IF, GNT_D, RESP.
- IDLE: `d_req` -> GNT_D; else `if_req` -> GNT_IF; else stay. Data has priority (older instruction).
- On entering GNT_x: latch requester address (bits [1:0] forced 0), `d_we`, `d_wdata`, `d_hw`, `addr[1]`; `mem_req`=1, all mem outputs stable for whole grant.
- GNT_x with `mem_ready`=1 -> RESP; capture/format read data into `x_rdata`; `mem_req`=0 in RESP.
- RESP: assert only the served requester's ack for exactly one cycle; no arbitration in RESP; -> IDLE.
- Load formatting: word -> pass through; half -> `addr[1]` ? `[31:16]` : `[15:0]`; mode 2'b11 sign-extends bit 15, 2'b10 zero-extends; mode 2'b01 treated as word.
- Stores: word only, `d_hw` ignored; `d_rdata` unchanged on store ack.
- Misaligned: word address bits [1:0] and half address bit [0] ignored, no fault.
- `mem_ready` in IDLE or RESP ignored.

## Timing
- Reset (async, `reset`=0): state IDLE; `if_ack`, `d_ack`, `mem_req`, `mem_we`=0; `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata`=0; starve counter 0. In-flight access abandoned; late `mem_ready` ignored.
- Req high at edge N (state IDLE) -> `mem_req`=1 from N+1; `mem_ready` at edge N+k (k≥1) -> ack high cycle N+k..N+k+1, IDLE next. Minimum 3 cycles req-to-ack-end, zero-wait memory.
- Requester drops or renews req after sampling ack; IDLE following RESP re-arbitrates with fresh inputs (back-to-back throughput one access per 3 cycles + wait states).
- Simultaneous `if_req` and `d_req` in IDLE: data wins; fetch served next IDLE.
- Request inputs changing during grant have no effect (latched).

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined: saturating counter increments on each data grant while `if_req`=1, clears on fetch grant or when `if_req`=0; at `STARVE_MAX` the next IDLE arbitration grants fetch even if `d_req`=1.
- Undefined: strict data priority, counter not instantiated.

## Structure
- Shared `mips_pkg`: `arb_state_t` enum (IDLE, GNT_IF, GNT_D, RESP), constants `HW_WORD`=2'b00, `HW_UHALF`=2'b10, `HW_SHALF`=2'b11 (also used by main control).
- Sub-module `load_formatter`: combinational half/word select and extension from `mem_rdata`, `d_hw`, `addr[1]`.

## Test plan
- Fetch only, `if_addr`=0x40, memory 2 wait cycles returns 0x8C220004 -> `mem_addr`=0x40 held 3 cycles, `if_ack` one cycle, `if_rdata`=0x8C220004.
- Both req same cycle, `d_addr`=0x100 store 0xDEADBEEF -> GNT_D first (`mem_we`=1, `mem_wdata`=0xDEADBEEF), `d_ack`, then fetch granted.
- Load `d_addr`=0x102 mode 2'b11, `mem_rdata`=0x8001_1234 -> `d_rdata`=0xFFFF8001; mode 2'b10 -> 0x00008001; `d_addr`=0x100 mode 2'b11 -> 0x00001234.
- Reset deasserted-asserted mid GNT_D then `mem_ready` pulse in IDLE -> no ack, all outputs 0, next request served normally.
- Guard build, `STARVE_MAX`=4, `d_req` continuous and `if_req` high -> 4 data acks then one `if_ack`; non-guard build -> no `if_ack` while `d_req` held.
